// File: rtl/pc_sequencer_if.sv
// Control-unit <-> program-counter bus: sequencing controls in, pc and stack status out.
interface pc_sequencer_if #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) ();
  logic [W-1:0]                 pc_start;
  logic                         en;
  logic                         br;
  logic                         jmp;
  logic                         call;
  logic                         ret;
  logic [W-1:0]                 offset;
  logic [W-1:0]                 target;
  logic [W-1:0]                 pc;
  logic [$clog2(DEPTH+1)-1:0]   depth;
  logic                         stk_full;
  logic                         stk_empty;
  logic                         stk_err;

  modport master (
    output pc_start, en, br, jmp, call, ret, offset, target,
    input  pc, depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  pc_start, en, br, jmp, call, ret, offset, target,
    output pc, depth, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with sequential advance, relative branch, absolute jump and
// call/return through a small LIFO return-address stack.
module pc_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int INC   = 1
) (
  input logic            clk,
  input logic            clr,
  pc_sequencer_if.slave  bus
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  stack [DEPTH];
  logic [W-1:0]  pc_q;
  logic [DW-1:0] depth_q;
  logic          err_q;

  logic [W-1:0]  pc_inc;
  logic          full;
  logic          empty;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic          do_ret;
  logic          do_call;
  logic          push;

  // Next-address arithmetic, stack decodes and action selection
  always_comb begin
    pc_inc   = pc_q + W'(INC);
    full     = (depth_q == DW'(DEPTH));
    empty    = (depth_q == '0);
    // depth_q < DEPTH whenever a push happens and > 0 whenever a pop happens,
    // so truncation to the RAM index width never loses information there.
    push_idx = AW'(depth_q);
    pop_idx  = AW'(depth_q - DW'(1));
    do_ret   = bus.en & bus.ret;
    do_call  = bus.en & ~bus.ret & bus.call;
    push     = ~clr & do_call & ~full;
  end

  // Return-address RAM; contents need no reset
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

  // PC, stack depth and sticky error; ret > call > jmp > br > sequential
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q    <= bus.pc_start;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.en) begin
      if (do_ret) begin
        if (empty) begin
          err_q <= 1'b1;
        end else begin
          pc_q    <= stack[pop_idx];
          depth_q <= depth_q - DW'(1);
        end
      end else if (do_call) begin
        if (full) begin
          err_q <= 1'b1;
        end else begin
          pc_q    <= bus.target;
          depth_q <= depth_q + DW'(1);
        end
      end else if (bus.jmp) begin
        pc_q <= bus.target;
      end else if (bus.br) begin
        pc_q <= pc_inc + bus.offset;
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  // Registered state onto the bus
  always_comb begin
    bus.pc        = pc_q;
    bus.depth     = depth_q;
    bus.stk_full  = full;
    bus.stk_empty = empty;
    bus.stk_err   = err_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic clr;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  pc_sequencer_if #(.W(16), .DEPTH(4)) bus ();

  pc_sequencer #(.W(16), .DEPTH(4), .INC(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.br = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.offset = '0; bus.target = '0;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] p, input int unsigned d,
                           input logic e);
    check({tag, ".pc"},    32'(bus.pc),    32'(p));
    check({tag, ".depth"}, 32'(bus.depth), d);
    check({tag, ".err"},   32'(bus.stk_err), 32'(e));
  endtask

  initial begin
    logic [15:0] tgt [4];
    logic [15:0] rta [4];
    tgt[0] = 16'h0200; tgt[1] = 16'h0300; tgt[2] = 16'h0400; tgt[3] = 16'h0500;
    rta[0] = 16'h0042; rta[1] = 16'h0201; rta[2] = 16'h0301; rta[3] = 16'h0401;

    // 1. reset and sequential advance
    idle();
    bus.en = 1'b0;
    bus.pc_start = 16'h0010;
    clr = 1'b1;
    step();
    chk_state("reset", 16'h0010, 0, 1'b0);
    check("reset.empty", 32'(bus.stk_empty), 1);
    check("reset.full",  32'(bus.stk_full),  0);
    clr = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq.pc", 32'(bus.pc), 32'h10 + 32'(i));
    end

    // 2. branch with negative offset, then wrap at top of address space
    bus.jmp = 1'b1; bus.target = 16'h0020;
    step();
    check("jmp.pc", 32'(bus.pc), 32'h0020);
    idle();
    bus.br = 1'b1; bus.offset = 16'hFFFE;
    step();
    check("br_neg.pc", 32'(bus.pc), 32'h001F);
    idle();
    bus.jmp = 1'b1; bus.target = 16'hFFFF;
    step();
    idle();
    step();
    chk_state("wrap", 16'h0000, 0, 1'b0);

    // 3. call and return
    bus.jmp = 1'b1; bus.target = 16'h0040;
    step();
    idle();
    bus.call = 1'b1; bus.target = 16'h0100;
    step();
    chk_state("call", 16'h0100, 1, 1'b0);
    idle();
    bus.ret = 1'b1;
    step();
    chk_state("ret", 16'h0041, 0, 1'b0);
    check("ret.empty", 32'(bus.stk_empty), 1);

    // 4. overflow: four nested calls fill the stack, fifth is refused
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.call = 1'b1; bus.target = tgt[i];
      step();
    end
    chk_state("fill", 16'h0500, 4, 1'b0);
    check("fill.full", 32'(bus.stk_full), 1);
    bus.target = 16'h0600;
    step();
    chk_state("ovf", 16'h0500, 4, 1'b1);
    idle();
    for (int i = 3; i >= 0; i--) begin
      bus.ret = 1'b1;
      step();
      check("lifo.pc", 32'(bus.pc), 32'(rta[i]));
      check("lifo.depth", 32'(bus.depth), 32'(i));
    end

    // 5. underflow and priority
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("rst2.err", 32'(bus.stk_err), 0);
    bus.ret = 1'b1;
    step();
    chk_state("unf", 16'h0010, 0, 1'b1);
    idle();
    bus.call = 1'b1; bus.target = 16'h0080;
    step();
    check("call1.depth", 32'(bus.depth), 1);
    bus.call = 1'b1; bus.ret = 1'b1; bus.br = 1'b1;
    bus.target = 16'h0090; bus.offset = 16'h0005;
    step();
    chk_state("prio_ret", 16'h0011, 0, 1'b1);
    idle();
    bus.jmp = 1'b1; bus.br = 1'b1; bus.target = 16'h0030; bus.offset = 16'h0010;
    step();
    check("prio_jmp.pc", 32'(bus.pc), 32'h0030);
    idle();
    bus.call = 1'b1; bus.jmp = 1'b1; bus.target = 16'h0070;
    step();
    chk_state("prio_call", 16'h0070, 1, 1'b1);
    idle();
    bus.en = 1'b0; bus.br = 1'b1; bus.offset = 16'h0010;
    step();
    check("stall_br.pc", 32'(bus.pc), 32'h0070);
    idle();
    bus.ret = 1'b1;
    step();
    chk_state("stall_ret", 16'h0070, 1, 1'b1);
    bus.en = 1'b1;
    step();
    chk_state("ret2", 16'h0031, 0, 1'b1);

    // 6. reset wins over a simultaneous call
    idle();
    bus.call = 1'b1; bus.target = 16'h0200;
    step();
    bus.target = 16'h0300;
    step();
    chk_state("pre_rst", 16'h0300, 2, 1'b1);
    bus.pc_start = 16'h0ABC;
    bus.target = 16'h0999;
    clr = 1'b1;
    step();
    chk_state("rst_call", 16'h0ABC, 0, 1'b0);
    check("rst_call.empty", 32'(bus.stk_empty), 1);
    clr = 1'b0;
    idle();
    step();
    check("post_rst.pc", 32'(bus.pc), 32'h0ABD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
